// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// State encoding is fixed so waveforms and debug scripts can decode it directly.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int INSTR_W    = 32;

  // addi x0,x0,0 -- what the fetch stage substitutes for a dropped instruction
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [INSTR_W-1:0] pick_word(input logic [63:0] dword, input logic hi);
    return hi ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts busy cycles without a memory completion; expire is combinational and
// fires in the cycle that would reach TIMEOUT. TIMEOUT=0 never expires.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; all outputs registered,
// mem_req one cycle after grant, ack one cycle after mem_ready or watchdog expiry.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_flush,
  output logic               if_ack,
  output logic [INSTR_W-1:0] if_rdata,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic               dm_ack,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic               err
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  arb_state_t         state_q, state_d;
  logic [SW-1:0]      streak_q, streak_d;
  logic               discard_q, discard_d;
  logic               if_ack_q, if_ack_d;
  logic               dm_ack_q, dm_ack_d;
  logic               err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [INSTR_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;

  logic busy;
  logic wd_expire;
  logic flush_hit;
  logic unused_if_addr_lsb;

  assign busy               = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign unused_if_addr_lsb = ^if_addr[1:0];

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy),
    .en     (busy && !mem_ready),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    // a flush landing in the completion cycle still kills the fetch
    flush_hit   = discard_q || ((state_q == BUSY_IF) && if_flush);

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (dm_req && !(if_req && (streak_q == STREAK_MAX))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (if_req) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
          streak_d    = '0;
          discard_d   = if_flush;
        end
      end
      BUSY_IF, BUSY_DM: begin
        discard_d = flush_hit;
        if (mem_ready || wd_expire) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == BUSY_DM) begin
            dm_ack_d   = 1'b1;
            err_d      = !mem_ready;
            dm_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
          end else if (!flush_hit) begin
            if_ack_d   = 1'b1;
            err_d      = !mem_ready;
            if_rdata_d = mem_ready ? pick_word(mem_rdata[63:0], mem_addr_q[2]) : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      discard_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      discard_q   <= discard_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences, random traffic.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int MAXS  = 4;
  localparam int TO    = 8;
  localparam int NO    = -1;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_ack, dm_ack, mem_req, mem_we, err;
  logic [31:0]   if_rdata;
  logic [DW-1:0] dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd;
    int          dly;     // mem_ready in cycle 1+dly
    int          fc;      // cycle carrying if_flush, NO = none
    bit          e_ack;
    int          e_lat;
    bit          e_err;
    logic [63:0] e_data;
    int          e_reqc;
    bit          e_we;
    logic [63:0] e_maddr;
  } vec_t;

  vec_t tbl[14];
  logic [63:0] emem[8];
  logic [63:0] rmem[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s ctl", tag), {59'h0, if_ack, dm_ack, err, mem_req, mem_we}, 64'h0);
    chk($sformatf("%s mem_addr", tag), mem_addr, 64'h0);
    chk($sformatf("%s mem_wdata", tag), mem_wdata, 64'h0);
    chk($sformatf("%s if_rdata", tag), {32'h0, if_rdata}, 64'h0);
    chk($sformatf("%s dm_rdata", tag), dm_rdata, 64'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int n_if, n_dm, n_err, lat, reqc;
    logic [63:0] we1, ma1, dat;
    n_if = 0; n_dm = 0; n_err = 0; lat = -1; reqc = 0; we1 = '0; ma1 = '0;
    for (int c = 0; c < 20; c++) begin
      if_req    = (c == 0) && !v.is_dm;
      dm_req    = (c == 0) && v.is_dm;
      dm_we     = v.we;
      dm_addr   = v.addr;
      if_addr   = v.addr;
      dm_wdata  = v.wdata;
      if_flush  = (c == v.fc);
      mem_ready = (c == 1 + v.dly);
      mem_rdata = v.rd;
      cyc();
      if (c == 0) begin
        we1 = {63'h0, mem_we};
        ma1 = mem_addr;
      end
      if (mem_req) reqc++;
      if (if_ack) begin n_if++; lat = c + 1; end
      if (dm_ack) begin n_dm++; lat = c + 1; end
      if (err) n_err++;
    end
    idle_inputs();
    dat = v.is_dm ? dm_rdata : {32'h0, if_rdata};
    chk($sformatf("r%0d own acks", i), v.is_dm ? n_dm : n_if, {63'h0, v.e_ack});
    chk($sformatf("r%0d other acks", i), v.is_dm ? n_if : n_dm, 64'h0);
    chk($sformatf("r%0d ack cycle", i), lat, v.e_lat);
    chk($sformatf("r%0d err pulses", i), n_err, {63'h0, v.e_err});
    chk($sformatf("r%0d rdata", i), dat, v.e_data);
    chk($sformatf("r%0d mem_req cycles", i), reqc, v.e_reqc);
    chk($sformatf("r%0d mem_we", i), we1, {63'h0, v.e_we});
    chk($sformatf("r%0d mem_addr", i), ma1, v.e_maddr);
    chk($sformatf("r%0d mem_we after", i), {63'h0, mem_we}, 64'h0);
  endtask

  task automatic run_streak();
    int s, k;
    bit exp_if;
    do_reset();
    if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 64'h2000; if_addr = 64'h1000;
    mem_ready = 1; mem_rdata = 64'h1;
    s = 0; k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      cyc();
      if (if_ack || dm_ack) begin
        exp_if = (s == MAXS);
        chk($sformatf("streak grant %0d", k), {62'h0, if_ack, dm_ack}, exp_if ? 64'h2 : 64'h1);
        s = exp_if ? 0 : s + 1;
        k++;
      end
    end
    chk("streak ack count", k, 10);
    idle_inputs();
  endtask

  task automatic run_random(input int ncyc);
    bit ip, dp, dw, prev_if, prev_dm, prev_mreq;
    int side, streak_m, cd, idx, if_wait, max_wait, n_acks;
    logic [63:0] ia, da, dwd, exp_d;
    do_reset();
    ip = 0; dp = 0; dw = 0; prev_if = 0; prev_dm = 0; prev_mreq = 0;
    side = 0; streak_m = 0; cd = 0; if_wait = 0; max_wait = 0; n_acks = 0;
    ia = '0; da = '0; dwd = '0; exp_d = '0;
    for (int i = 0; i < 8; i++) begin
      emem[i] = {$urandom, $urandom};
      rmem[i] = emem[i];
    end
    for (int c = 0; c < ncyc; c++) begin
      if (mem_req && !prev_mreq) begin
        chk("rnd grant had request", {63'h0, prev_if | prev_dm}, 64'h1);
        if (prev_dm && !(prev_if && streak_m == MAXS)) begin
          side = 2;
          streak_m = prev_if ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
          chk("rnd dm addr", mem_addr, da);
          chk("rnd dm we", {63'h0, mem_we}, {63'h0, dw});
          idx = int'(da[5:3]);
          if (dw) begin
            chk("rnd dm wdata", mem_wdata, dwd);
            exp_d = '0;
            rmem[idx] = dwd;
          end else begin
            exp_d = rmem[idx];
          end
        end else begin
          side = 1;
          streak_m = 0;
          chk("rnd if addr", mem_addr, {ia[63:2], 2'b00});
          chk("rnd if we", {63'h0, mem_we}, 64'h0);
          idx = int'(ia[5:3]);
          exp_d = {32'h0, ia[2] ? rmem[idx][63:32] : rmem[idx][31:0]};
        end
        cd = $urandom_range(0, 3);
      end
      if (if_ack || dm_ack) begin
        chk("rnd ack side", {62'h0, if_ack, dm_ack},
            (side == 1) ? 64'h2 : (side == 2) ? 64'h1 : 64'h0);
        chk("rnd ack data", if_ack ? {32'h0, if_rdata} : dm_rdata, exp_d);
        chk("rnd ack err", {63'h0, err}, 64'h0);
        if (if_ack) begin
          ip = 0;
          if (if_wait > max_wait) max_wait = if_wait;
          if_wait = 0;
        end
        if (dm_ack) dp = 0;
        side = 0;
        n_acks++;
      end
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1;
        ia = 64'h4000 + 64'($urandom_range(0, 63));
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1;
        da = 64'h4000 + 64'($urandom_range(0, 7)) * 8;
        dw = 1'($urandom_range(0, 1));
        dwd = {$urandom, $urandom};
      end
      if (ip) if_wait++;
      if_req = ip; dm_req = dp; if_addr = ia; dm_addr = da; dm_we = dw; dm_wdata = dwd;
      if_flush = 0;
      mem_ready = 0;
      if (mem_req) begin
        if (cd == 0) begin
          mem_ready = 1;
          idx = int'(mem_addr[5:3]);
          mem_rdata = emem[idx];
          if (mem_we) emem[idx] = mem_wdata;
        end else begin
          cd--;
          mem_rdata = {$urandom, $urandom};
        end
      end
      prev_if = ip; prev_dm = dp; prev_mreq = mem_req;
      cyc();
    end
    chk("rnd enough acks", {63'h0, n_acks > 30}, 64'h1);
    chk("rnd if wait bounded", {63'h0, max_wait <= 45}, 64'h1);
    idle_inputs();
    mem_ready = 1;
    for (int c = 0; c < 10; c++) cyc();
    idle_inputs();
  endtask

  task automatic run_reset_mid();
    do_reset();
    run_vec(100, tbl[7]);
    dm_req = 1; dm_we = 0; dm_addr = 64'h2040; mem_ready = 0;
    cyc();
    dm_req = 0;
    cyc();
    chk("rstmid busy mem_req", {63'h0, mem_req}, 64'h1);
    rst = 1;
    cyc();
    chk_zero("rstmid");
    rst = 0;
    if_req = 1; if_addr = 64'h1004; mem_ready = 1; mem_rdata = 64'h5A5A_5A5A_C3C3_C3C3;
    cyc();
    chk("rstmid new mem_req", {63'h0, mem_req}, 64'h1);
    chk("rstmid new addr", mem_addr, 64'h1004);
    chk("rstmid no dm_ack", {63'h0, dm_ack}, 64'h0);
    if_req = 0;
    cyc();
    chk("rstmid acks", {62'h0, if_ack, dm_ack}, 64'h2);
    chk("rstmid if_rdata", {32'h0, if_rdata}, 64'h5A5A_5A5A);
    idle_inputs();
    cyc();
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 64'h1004, 64'h0, 64'hAAAA_BBBB_1111_2222, 0, NO, 1'b1, 2, 1'b0, 64'hAAAA_BBBB, 1, 1'b0, 64'h1004};
    tbl[1]  = '{1'b0, 1'b0, 64'h1000, 64'h0, 64'hAAAA_BBBB_1111_2222, 2, NO, 1'b1, 4, 1'b0, 64'h1111_2222, 3, 1'b0, 64'h1000};
    tbl[2]  = '{1'b0, 1'b0, 64'h1007, 64'h0, 64'h0BAD_0000_CAFE_F00D, 0, NO, 1'b1, 2, 1'b0, 64'h0BAD_0000, 1, 1'b0, 64'h1004};
    tbl[3]  = '{1'b0, 1'b0, 64'h1100, 64'h0, 64'h1234_5678_9ABC_DEF0, 2, 2,  1'b0, -1, 1'b0, 64'h0BAD_0000, 3, 1'b0, 64'h1100};
    tbl[4]  = '{1'b0, 1'b0, 64'h1200, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 0,  1'b0, -1, 1'b0, 64'h0BAD_0000, 1, 1'b0, 64'h1200};
    tbl[5]  = '{1'b0, 1'b0, 64'h1300, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 1,  1'b0, -1, 1'b0, 64'h0BAD_0000, 1, 1'b0, 64'h1300};
    tbl[6]  = '{1'b1, 1'b1, 64'h2000, 64'hDEAD_BEEF_0000_0001, 64'h5555, 0, NO, 1'b1, 2, 1'b0, 64'h0, 1, 1'b1, 64'h2000};
    tbl[7]  = '{1'b1, 1'b0, 64'h2000, 64'h0, 64'hDEAD_BEEF_0000_0001, 1, NO, 1'b1, 3, 1'b0, 64'hDEAD_BEEF_0000_0001, 2, 1'b0, 64'h2000};
    tbl[8]  = '{1'b1, 1'b0, 64'h2008, 64'h0, 64'h77, 0, 1, 1'b1, 2, 1'b0, 64'h77, 1, 1'b0, 64'h2008};
    tbl[9]  = '{1'b1, 1'b0, 64'h2010, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, NEVER, NO, 1'b1, 9, 1'b1, 64'h0, 8, 1'b0, 64'h2010};
    tbl[10] = '{1'b0, 1'b0, 64'h3000, 64'h0, 64'h0000_0001_0000_0002, 7, NO, 1'b1, 9, 1'b0, 64'h0000_0002, 8, 1'b0, 64'h3000};
    tbl[11] = '{1'b0, 1'b0, 64'h3004, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, NEVER, NO, 1'b1, 9, 1'b1, 64'h0, 8, 1'b0, 64'h3004};
    tbl[12] = '{1'b0, 1'b0, 64'h3008, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, NEVER, 3, 1'b0, -1, 1'b0, 64'h0, 8, 1'b0, 64'h3008};
    tbl[13] = '{1'b1, 1'b1, 64'h2018, 64'h0123_4567_89AB_CDEF, 64'h0, NEVER, NO, 1'b1, 9, 1'b1, 64'h0, 8, 1'b1, 64'h2018};

    idle_inputs();
    rst = 1;
    cyc(); cyc(); cyc();
    chk_zero("reset");
    rst = 0;
    cyc();
    chk_zero("after reset idle");

    for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

    run_streak();
    run_random(1500);
    run_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
